// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared types and constants for the pipeline hazard unit
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] PC_REG = 4'hF;

  // Memory-wait counter width; MEM_TIMEOUT must fit in it.
  localparam int CNT_W = 8;

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline status in, hazard controls out
interface hazard_unit_if #(
  parameter int REG_W = 4
);
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rd;
  logic [REG_W-1:0] ex_rd;
  logic             ex_rf_en;
  logic             ex_load;
  logic [REG_W-1:0] mem_rd;
  logic             mem_rf_en;
  logic [REG_W-1:0] wb_rd;
  logic             wb_rf_en;
  logic             branch_taken;
  logic             dmem_en;
  logic             dmem_ready;

  logic             nop_sel;
  logic             pc_le;
  logic             ifid_le;
  logic             ifid_flush;
  logic             pipe_freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       fwd_c;
  logic             mem_fault;

  modport master (
    output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    output ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en, wb_rd, wb_rf_en,
    output branch_taken, dmem_en, dmem_ready,
    input  nop_sel, pc_le, ifid_le, ifid_flush, pipe_freeze,
    input  fwd_a, fwd_b, fwd_c, mem_fault
  );

  modport slave (
    input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    input  ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en, wb_rd, wb_rf_en,
    input  branch_taken, dmem_en, dmem_ready,
    output nop_sel, pc_le, ifid_le, ifid_flush, pipe_freeze,
    output fwd_a, fwd_b, fwd_c, mem_fault
  );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// rtl/hazard_unit_fwd_sel.sv - single-operand forwarding priority selector (EX > MEM > WB)
module hazard_unit_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_rf_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_rf_en,
  output logic [1:0]       fwd
);

  always_comb begin
    fwd = FWD_RF;
    // R15 reads the PC path, never a forwarded result.
    if (use_src && (src != REG_W'(PC_REG))) begin
      if (ex_rf_en && !ex_load && (ex_rd == src)) begin
        fwd = FWD_EX;
      end else if (mem_rf_en && (mem_rd == src)) begin
        fwd = FWD_MEM;
      end else if (wb_rf_en && (wb_rd == src)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use/branch/memory-wait hazard controller with forwarding selects
// Optional HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] fwd_a_c, fwd_b_c, fwd_c_c;
  logic       lu;
  logic       mem_stall;
  logic       nop_sel_c, pc_le_c, ifid_le_c, ifid_flush_c, freeze_c;

  hazard_unit_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src(hz.id_rn), .use_src(hz.id_use_rn),
    .ex_rd(hz.ex_rd), .ex_rf_en(hz.ex_rf_en), .ex_load(hz.ex_load),
    .mem_rd(hz.mem_rd), .mem_rf_en(hz.mem_rf_en),
    .wb_rd(hz.wb_rd), .wb_rf_en(hz.wb_rf_en),
    .fwd(fwd_a_c)
  );

  hazard_unit_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src(hz.id_rm), .use_src(hz.id_use_rm),
    .ex_rd(hz.ex_rd), .ex_rf_en(hz.ex_rf_en), .ex_load(hz.ex_load),
    .mem_rd(hz.mem_rd), .mem_rf_en(hz.mem_rf_en),
    .wb_rd(hz.wb_rd), .wb_rf_en(hz.wb_rf_en),
    .fwd(fwd_b_c)
  );

  hazard_unit_fwd_sel #(.REG_W(REG_W)) u_fwd_c (
    .src(hz.id_rd), .use_src(hz.id_use_rd),
    .ex_rd(hz.ex_rd), .ex_rf_en(hz.ex_rf_en), .ex_load(hz.ex_load),
    .mem_rd(hz.mem_rd), .mem_rf_en(hz.mem_rf_en),
    .wb_rd(hz.wb_rd), .wb_rf_en(hz.wb_rf_en),
    .fwd(fwd_c_c)
  );

  always_comb begin
    lu = hz.ex_load && hz.ex_rf_en && (hz.ex_rd != REG_W'(PC_REG)) &&
         ((hz.id_use_rn && (hz.id_rn == hz.ex_rd)) ||
          (hz.id_use_rm && (hz.id_rm == hz.ex_rd)) ||
          (hz.id_use_rd && (hz.id_rd == hz.ex_rd)));
    mem_stall = hz.dmem_en && !hz.dmem_ready;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nop_sel_c    = 1'b0;
    pc_le_c      = 1'b1;
    ifid_le_c    = 1'b1;
    ifid_flush_c = 1'b0;
    freeze_c     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze_c  = 1'b1;
          pc_le_c   = 1'b0;
          ifid_le_c = 1'b0;
          state_d   = WAIT;
          cnt_d     = CNT_W'(1);
        end else if (lu) begin
          // Bubble into ID/EX; a coincident branch is re-resolved next cycle.
          nop_sel_c = 1'b1;
          pc_le_c   = 1'b0;
          ifid_le_c = 1'b0;
        end else if (hz.branch_taken) begin
          ifid_flush_c = 1'b1;
        end
      end
      WAIT: begin
        freeze_c  = 1'b1;
        pc_le_c   = 1'b0;
        ifid_le_c = 1'b0;
        if (!hz.dmem_en || hz.dmem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_d = FAULT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FAULT: begin
        nop_sel_c = 1'b1;
        freeze_c  = 1'b1;
        pc_le_c   = 1'b0;
        ifid_le_c = 1'b0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset overrides every control so the pipeline holds a NOP in ID.
  assign hz.nop_sel     = !rst_n || nop_sel_c;
  assign hz.pc_le       = rst_n && pc_le_c;
  assign hz.ifid_le     = rst_n && ifid_le_c;
  assign hz.ifid_flush  = rst_n && ifid_flush_c;
  assign hz.pipe_freeze = rst_n && freeze_c;
  assign hz.fwd_a       = rst_n ? fwd_a_c : FWD_RF;
  assign hz.fwd_b       = rst_n ? fwd_b_c : FWD_RF;
  assign hz.fwd_c       = rst_n ? fwd_c_c : FWD_RF;
  assign hz.mem_fault   = rst_n && (state_q == FAULT);

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((lu || freeze_c) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (ifid_flush_c && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
